// File: rtl/uart_tx_fsm_ctrl.sv
// rtl/uart_tx_fsm_ctrl.sv - UART transmit frame sequencer (start, LSB-first data, optional parity, stop)
// Optional feature: define UART_TX_TWO_STOP_EN to append a second stop bit (STOP2 state).
module uart_tx_fsm_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TICK,
  input  logic             DATA_VALID,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             PAR_EN,
  input  logic             PAR_BIT,
  output logic             TX_OUT,
  output logic             Busy,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef UART_TX_TWO_STOP_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_STOP2  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_en_q, par_en_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and next-output decode; every non-idle state only moves on a baud tick
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    par_en_d = par_en_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Accept is immediate; the start bit length is measured from the next tick
        if (DATA_VALID) begin
          state_d  = S_START;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
          shift_d  = P_DATA;
          par_en_d = PAR_EN;
        end
      end

      S_START: begin
        if (TICK) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[WIDTH-1:1]};
          cnt_d   = '0;
        end
      end

      S_DATA: begin
        if (TICK) begin
          if (cnt_q != CNT_LAST) begin
            cnt_d   = cnt_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[WIDTH-1:1]};
          end else if (par_en_q) begin
            // parity_calc has long settled by now, so sampling here is safe
            state_d = S_PARITY;
            tx_d    = PAR_BIT;
          end else begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (TICK) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end

      S_STOP: begin
        if (TICK) begin
`ifdef UART_TX_TWO_STOP_EN
          state_d = S_STOP2;
          tx_d    = 1'b1;
`else
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end
      end

`ifdef UART_TX_TWO_STOP_EN
      S_STOP2: begin
        if (TICK) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame and forces the line idle-high
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      par_en_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      par_en_q <= par_en_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_uart_tx_fsm_ctrl.sv
// tb/tb_uart_tx_fsm_ctrl.sv - randomized self-checking bench for uart_tx_fsm_ctrl
module tb_uart_tx_fsm_ctrl;

  localparam int WIDTH = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic             CLK = 1'b0;
  logic             RST;
  logic             TICK;
  logic             DATA_VALID;
  logic [WIDTH-1:0] P_DATA;
  logic             PAR_EN;
  logic             PAR_BIT;
  logic             TX_OUT;
  logic             Busy;
  logic             DONE;

  int n_total = 0;
  int n_pass  = 0;
  logic chk_en = 1'b0;

  uart_tx_fsm_ctrl #(.WIDTH(WIDTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .TICK       (TICK),
    .DATA_VALID (DATA_VALID),
    .P_DATA     (P_DATA),
    .PAR_EN     (PAR_EN),
    .PAR_BIT    (PAR_BIT),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy),
    .DONE       (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: a frame is a list of line levels, one per tick; parity slot filled on arrival
  logic m_tx = 1'b1;
  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  int   m_idx = 0;
  int   m_len = 0;
  int   m_par_pos = -1;
  logic m_bits [0:15];

  always @(posedge CLK) begin
    m_done = 1'b0;
    if (!RST) begin
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (DATA_VALID) begin
        int pos;
        m_bits[0] = 1'b0;
        for (int i = 0; i < WIDTH; i++) m_bits[1 + i] = P_DATA[i];
        pos = 1 + WIDTH;
        if (PAR_EN) begin
          m_par_pos = pos;
          pos++;
        end else begin
          m_par_pos = -1;
        end
        for (int s = 0; s < NSTOP; s++) begin
          m_bits[pos] = 1'b1;
          pos++;
        end
        m_len  = pos;
        m_idx  = 0;
        m_tx   = 1'b0;
        m_busy = 1'b1;
      end
    end else if (TICK) begin
      m_idx++;
      if (m_idx == m_len) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_tx   = 1'b1;
      end else if (m_idx == m_par_pos) begin
        m_tx = PAR_BIT;
      end else begin
        m_tx = m_bits[m_idx];
      end
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the active edge
  always @(negedge CLK) begin
    if (chk_en) begin
      check("cyc_tx", int'(TX_OUT), int'(m_tx));
      check("cyc_busy", int'(Busy), int'(m_busy));
      check("cyc_done", int'(DONE), int'(m_done));
    end
  end

  // Accept one word with TICK=1 and record 14 post-edge samples
  task automatic capture(input logic [7:0] data, input logic pe, input logic pb,
                         output logic [13:0] txv, output int busy_cnt, output int done_idx);
    TICK = 1'b1; DATA_VALID = 1'b1; P_DATA = data; PAR_EN = pe; PAR_BIT = pb;
    step();
    DATA_VALID = 1'b0;
    busy_cnt = 0;
    done_idx = -1;
    for (int i = 0; i < 14; i++) begin
      txv[i] = TX_OUT;
      if (Busy) busy_cnt++;
      if (DONE && done_idx < 0) done_idx = i;
      step();
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    DATA_VALID = 1'b0;
    TICK = 1'b1;
    k = 0;
    while (Busy && k < 200) begin
      step();
      k++;
    end
    if (k >= 200) check({name, "_idle_timeout"}, 1, 0);
    step();
  endtask

  logic [13:0] txv;
  logic [25:0] tx2;
  logic [25:0] bz2;
  int   busy_cnt, done_idx;
  logic prev_tx, last_tick;
  logic [7:0] b1, b2;

  initial begin
    RST = 1'b0; TICK = 1'b0; DATA_VALID = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_BIT = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    check("rst_tx", int'(TX_OUT), 1);
    check("rst_busy", int'(Busy), 0);
    check("rst_done", int'(DONE), 0);
    RST = 1'b1;
    TICK = 1'b1;
    step();
    check("tick_idle_tx", int'(TX_OUT), 1);
    check("tick_idle_busy", int'(Busy), 0);

    // 8'hA5, no parity
    capture(8'hA5, 1'b0, 1'b0, txv, busy_cnt, done_idx);
    check("a5_tx_seq", int'(txv[11:0]), 12'hF4A);
    check("a5_busy_cycles", busy_cnt, 9 + NSTOP);
    check("a5_done_idx", done_idx, 9 + NSTOP);

    // 8'h03 with parity, PAR_BIT=0
    capture(8'h03, 1'b1, 1'b0, txv, busy_cnt, done_idx);
    check("p03_tx_seq", int'(txv[11:0]), 12'hC06);
    check("p03_busy_cycles", busy_cnt, 10 + NSTOP);
    check("p03_done_idx", done_idx, 10 + NSTOP);

    // 8'hFF, TICK every 4th cycle, competing DATA_VALID with 8'h00 ignored
    TICK = 1'b0; DATA_VALID = 1'b1; P_DATA = 8'hFF; PAR_EN = 1'b0;
    step();
    prev_tx = TX_OUT;
    check("ff_start_tx", int'(TX_OUT), 0);
    P_DATA = 8'h00;
    for (int k = 0; k < 4 * (9 + NSTOP); k++) begin
      last_tick = (k % 4 == 3);
      TICK = last_tick;
      step();
      if (TX_OUT != prev_tx && !last_tick) check("ff_edge_off_tick", 1, 0);
      prev_tx = TX_OUT;
    end
    check("ff_no_zero_data", int'(Busy), 0);
    wait_idle("ff");

    // Back-to-back with DATA_VALID held: 8'h55 then 8'hAA
    TICK = 1'b1; DATA_VALID = 1'b1; P_DATA = 8'h55; PAR_EN = 1'b0;
    step();
    P_DATA = 8'hAA;
    done_idx = -1;
    for (int i = 0; i < 26; i++) begin
      tx2[i] = TX_OUT;
      bz2[i] = Busy;
      if (DONE && done_idx < 0) done_idx = i;
      step();
    end
    DATA_VALID = 1'b0;
    check("b2b_done_idx", done_idx, 9 + NSTOP);
    if (done_idx >= 0 && done_idx < 14) begin
      check("b2b_gap_tx", int'(tx2[done_idx]), 1);
      check("b2b_gap_busy", int'(bz2[done_idx]), 0);
      check("b2b_start2_tx", int'(tx2[done_idx + 1]), 0);
      check("b2b_start2_busy", int'(bz2[done_idx + 1]), 1);
      for (int i = 0; i < 8; i++) begin
        b1[i] = tx2[1 + i];
        b2[i] = tx2[done_idx + 2 + i];
      end
      check("b2b_word1", int'(b1), 8'h55);
      check("b2b_word2", int'(b2), 8'hAA);
    end
    wait_idle("b2b");

    // Reset mid-DATA aborts the frame
    TICK = 1'b1; DATA_VALID = 1'b1; P_DATA = 8'h00; PAR_EN = 1'b1;
    step();
    DATA_VALID = 1'b0;
    for (int i = 0; i < 4; i++) step();
    RST = 1'b0;
    step();
    check("abort_tx", int'(TX_OUT), 1);
    check("abort_busy", int'(Busy), 0);
    check("abort_done", int'(DONE), 0);
    step();
    RST = 1'b1;
    step();
    check("abort_idle_busy", int'(Busy), 0);

    // Randomized traffic: tick patterns, parity, stray valids, rare resets
    for (int c = 0; c < 6000; c++) begin
      case ((c / 500) % 3)
        0:       TICK = 1'b1;
        1:       TICK = (c % 4 == 0);
        default: TICK = ($urandom % 3 == 0);
      endcase
      DATA_VALID = ($urandom % 4 == 0);
      P_DATA     = WIDTH'($urandom);
      PAR_EN     = $urandom % 2;
      PAR_BIT    = $urandom % 2;
      RST        = ($urandom % 500 != 0);
      step();
    end
    RST = 1'b1;
    wait_idle("rand");

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
